// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC poller: RTC command codes, Wishbone byte
// selects, FSM state encodings and the command-per-slot lookup.
package rtc_pkg;

    localparam logic [7:0] CMD_SEC  = 8'h00;
    localparam logic [7:0] CMD_MIN  = 8'h02;
    localparam logic [7:0] CMD_HOUR = 8'h04;

    localparam logic [3:0] SEL_CMD  = 4'b0001;
    localparam logic [3:0] SEL_RD   = 4'b0011;

    // Sequencer states (rtc_reader)
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP,
        ST_CHECK
    } rd_state_e;

    // Single-transfer engine states (wb_single_xfer)
    typedef enum logic [1:0] {
        XF_IDLE,
        XF_REQ,
        XF_GAP
    } xf_state_e;

    // Slot 0: seconds, 1: minutes, 2: hours, 3: seconds re-read.
    function automatic logic [7:0] cmd_for_slot(input logic [1:0] slot);
        case (slot)
            2'd1:    return CMD_MIN;
            2'd2:    return CMD_HOUR;
            default: return CMD_SEC;
        endcase
    endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone classic transfer: REQ (cyc/stb held until ack or timeout)
// followed by a single GAP cycle. A start seen in IDLE or GAP launches REQ on
// the next cycle, so back-to-back transfers cost REQ cycles + 1.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i             launch a transfer with we_i/sel_i/wdata_i
//   m_*                 Wishbone master side
//   done_o              ack seen in REQ (rdata_o valid this cycle)
//   timeout_o           REQ expired without ack
module wb_single_xfer
    import rtc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdata_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] rdata_o
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    xf_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic        in_req;

    assign in_req    = (state_q == XF_REQ);
    assign m_cyc_o   = in_req;
    assign m_stb_o   = in_req;
    assign m_we_o    = in_req & we_q;
    assign m_sel_o   = in_req ? sel_q : '0;
    assign m_dat_o   = in_req ? dat_q : '0;
    // ack is only meaningful in REQ; the slave's late ack lands in GAP.
    assign done_o    = in_req & m_ack_i;
    assign timeout_o = in_req & ~m_ack_i & (cnt_q == TMO_LAST);
    assign rdata_o   = m_dat_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        case (state_q)
            XF_IDLE, XF_GAP: begin
                if (start_i) begin
                    state_d = XF_REQ;
                    cnt_d   = '0;
                    we_d    = we_i;
                    sel_d   = sel_i;
                    dat_d   = wdata_i;
                end else begin
                    state_d = XF_IDLE;
                end
            end
            XF_REQ: begin
                if (m_ack_i || cnt_q == TMO_LAST) begin
                    state_d = XF_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = XF_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= XF_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
        end
    end

endmodule

// File: rtl/rtc_reader.sv
// Periodic Wishbone reader of the RTC peripheral. Each poll writes a command
// byte then reads {value, echo} for seconds, minutes, hours and seconds again;
// the snapshot is published only if both second reads agree.
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-low reset
//   trigger_i                       immediate poll request
//   m_cyc_o .. m_ack_i              Wishbone master bus
//   second_o/minute_o/hour_o        BCD time of last good poll
//   valid_o                         one-cycle pulse on time update
//   busy_o                          poll sequence in progress
//   err_o                           sticky error, cleared by a good poll
module rtc_reader
    import rtc_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ  = 50000000,
    parameter int unsigned POLL_CYCLES = CLOCK_FREQ / 4,
    parameter logic [31:0] RTC_BASE    = 32'h0000_0000,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned MAX_TRIES   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trigger_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic [7:0]  second_o,
    output logic [7:0]  minute_o,
    output logic [7:0]  hour_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);

    rd_state_e   state_q, state_d;
    logic [2:0]  idx_q, idx_d;      // transfer number; bit 0 set = read
    logic [7:0]  tries_q, tries_d;
    logic        abort_q, abort_d;
    logic        pend_q, pend_d;
    logic [31:0] poll_cnt_q, poll_cnt_d;
    logic [7:0]  rd_q [4];
    logic [7:0]  rd_d [4];
    logic [7:0]  sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic        valid_q, valid_d, err_q, err_d;

    logic        poll_hit, req_start;
    logic        xfer_start, xfer_done, xfer_timeout;
    logic [7:0]  cur_cmd;
    logic [31:0] xfer_rdata;
    logic        unused_rdata;

    assign cur_cmd   = cmd_for_slot(idx_q[2:1]);
    assign poll_hit  = (POLL_CYCLES != 0) && (poll_cnt_q == POLL_LAST);
    assign req_start = trigger_i | poll_hit;
    assign unused_rdata = ^xfer_rdata[31:16];

    wb_single_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
        .clk_i     (clk_i),
        .rst_ni    (rst_i),
        .start_i   (xfer_start),
        .we_i      (~idx_q[0]),
        .sel_i     (idx_q[0] ? SEL_RD : SEL_CMD),
        .wdata_i   ({24'b0, cur_cmd}),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_we_o    (m_we_o),
        .m_sel_o   (m_sel_o),
        .m_dat_o   (m_dat_o),
        .m_dat_i   (m_dat_i),
        .m_ack_i   (m_ack_i),
        .done_o    (xfer_done),
        .timeout_o (xfer_timeout),
        .rdata_o   (xfer_rdata)
    );

    assign m_adr_o  = RTC_BASE;
    assign second_o = sec_q;
    assign minute_o = min_q;
    assign hour_o   = hour_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;
    assign busy_o   = (state_q != ST_IDLE);

    // xfer_start is combinational so the engine's REQ lines up with ours:
    // issued in IDLE/GAP/CHECK, the transfer's REQ begins the next cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tries_d    = tries_q;
        abort_d    = abort_q;
        pend_d     = pend_q;
        rd_d       = rd_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        xfer_start = 1'b0;

        poll_cnt_d = '0;
        if (POLL_CYCLES != 0) begin
            poll_cnt_d = poll_hit ? '0 : poll_cnt_q + 32'd1;
        end

        if (state_q != ST_IDLE && req_start) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_start || pend_q) begin
                    state_d    = ST_REQ;
                    xfer_start = 1'b1;
                    idx_d      = '0;
                    tries_d    = 8'd1;
                    abort_d    = 1'b0;
                    pend_d     = 1'b0;
                end
            end
            ST_REQ: begin
                if (xfer_done) begin
                    state_d = ST_GAP;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q[0]) begin
                        rd_d[idx_q[2:1]] = xfer_rdata[15:8];
                        if (xfer_rdata[7:0] != cur_cmd) begin
                            abort_d = 1'b1;
                            err_d   = 1'b1;
                        end
                    end
                end else if (xfer_timeout) begin
                    state_d = ST_GAP;
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                end
            end
            ST_GAP: begin
                // idx wraps to 0 after the eighth transfer.
                if (abort_q) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (idx_q == 3'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d    = ST_REQ;
                    xfer_start = 1'b1;
                end
            end
            ST_CHECK: begin
                if (rd_q[0] == rd_q[3]) begin
                    sec_d   = rd_q[0];
                    min_d   = rd_q[1];
                    hour_d  = rd_q[2];
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (tries_q < 8'(MAX_TRIES)) begin
                    tries_d    = tries_q + 8'd1;
                    state_d    = ST_REQ;
                    xfer_start = 1'b1;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tries_q    <= '0;
            abort_q    <= 1'b0;
            pend_q     <= 1'b0;
            poll_cnt_q <= '0;
            rd_q       <= '{default: '0};
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tries_q    <= tries_d;
            abort_q    <= abort_d;
            pend_q     <= pend_d;
            poll_cnt_q <= poll_cnt_d;
            rd_q       <= rd_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

endmodule
